spram_req_ctrl: RTL and testbench

SPRAM_REQ_CTRL -- requirements
Module: spram_req_ctrl

---
 rtl/spram_req_ctrl.sv | 114 +++++++++++
 tb/tb_spram_req_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spram_req_ctrl.sv
// Request/response controller for a single-port byte-enable RAM: passes requests straight
// to the RAM and collects read data into a credit-limited response FIFO.
module spram_req_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int OUT_REGS   = 0,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  ReqValid_SI,
    output logic                  ReqReady_SO,
    input  logic                  ReqWrEn_SI,
    input  logic [7:0]            ReqBEn_SI,
    input  logic [ADDR_WIDTH-1:0] ReqAddr_DI,
    input  logic [63:0]           ReqWrData_DI,
    output logic                  RspValid_SO,
    input  logic                  RspReady_SI,
    output logic [63:0]           RspData_DO,
    output logic                  RamCSel_SO,
    output logic                  RamWrEn_SO,
    output logic [7:0]            RamBEn_SO,
    output logic [ADDR_WIDTH-1:0] RamAddr_DO,
    output logic [63:0]           RamWrData_DO,
    input  logic [63:0]           RamRdData_DI
);
    localparam int LAT   = 1 + OUT_REGS;
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    logic             run;
    logic [CNT_W-1:0] credit;
    logic [LAT-1:0]   vld_p;
    logic [63:0]      mem [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             rsp_vld;
    logic [63:0]      rsp_data;

    logic fire, rd_fire, push, pop, load, take, bypass, store;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // run holds ready low until the first edge after reset release
    assign ReqReady_SO  = run & (credit < CNT_W'(RSP_DEPTH));
    assign fire         = ReqValid_SI & ReqReady_SO;
    assign rd_fire      = fire & ~ReqWrEn_SI;
    assign RamCSel_SO   = fire;
    assign RamWrEn_SO   = fire & ReqWrEn_SI;
    assign RamBEn_SO    = ReqBEn_SI;
    assign RamAddr_DO   = ReqAddr_DI;
    assign RamWrData_DO = ReqWrData_DI;

    assign push   = vld_p[LAT-1];
    assign pop    = rsp_vld & RspReady_SI;
    assign load   = ~rsp_vld | pop;
    assign take   = load & (count != '0);
    // An empty FIFO lets returning RAM data go straight to the output register
    assign bypass = load & (count == '0) & push;
    assign store  = push & ~bypass;

    assign RspValid_SO = rsp_vld;
    assign RspData_DO  = rsp_data;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            run      <= 1'b0;
            credit   <= '0;
            vld_p    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rsp_vld  <= 1'b0;
            rsp_data <= '0;
        end else begin
            run <= 1'b1;
            if (rd_fire && !pop) begin
                credit <= credit + 1'b1;
            end else if (!rd_fire && pop) begin
                credit <= credit - 1'b1;
            end
            vld_p[0] <= rd_fire;
            for (int i = 1; i < LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
            if (store) wr_ptr <= ptr_next(wr_ptr);
            if (take)  rd_ptr <= ptr_next(rd_ptr);
            if (store && !take) begin
                count <= count + 1'b1;
            end else if (take && !store) begin
                count <= count - 1'b1;
            end
            if (load) rsp_vld <= take | bypass;
            if (take) begin
                rsp_data <= mem[rd_ptr];
            end else if (bypass) begin
                rsp_data <= RamRdData_DI;
            end
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (store) mem[wr_ptr] <= RamRdData_DI;
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RBI) begin
            assert (RSP_DEPTH >= LAT + 1);
            assert (!(store && count == CNT_W'(RSP_DEPTH)));
        end
    end
endmodule

// File: tb/tb_spram_req_ctrl.sv
// Randomized bench for spram_req_ctrl: a scoreboard of pending reads with due cycles predicts
// ready, response valid/data and RAM strobes; a second instance covers OUT_REGS=1 latency.
module tb_spram_req_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance with OUT_REGS=0
    logic        req_valid, req_ready, req_wr, rsp_valid, rsp_ready;
    logic [7:0]  req_ben, req_addr;
    logic [63:0] req_wdata, rsp_data;
    logic        ram_csel, ram_wr;
    logic [7:0]  ram_ben, ram_addr;
    logic [63:0] ram_wdata, ram_rdata;

    // instance with OUT_REGS=1
    logic        req_valid1, req_ready1, req_wr1, rsp_valid1, rsp_ready1;
    logic [7:0]  req_ben1, req_addr1;
    logic [63:0] req_wdata1, rsp_data1;
    logic        ram_csel1, ram_wr1;
    logic [7:0]  ram_ben1, ram_addr1;
    logic [63:0] ram_wdata1, ram_rdata1, ram_rd1a;

    logic [63:0] ram0 [256];
    logic [63:0] ram1 [256];
    logic [63:0] shadow [256];

    typedef struct packed {
        logic [63:0] data;
        logic [31:0] due;
    } rsp_t;
    rsp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic        obs_vld, obs_fire, obs_ready;
    logic [63:0] obs_data;

    spram_req_ctrl #(.ADDR_WIDTH(8), .OUT_REGS(0), .RSP_DEPTH(4)) dut (
        .Clk_CI(clk), .Rst_RBI(rst_n),
        .ReqValid_SI(req_valid), .ReqReady_SO(req_ready), .ReqWrEn_SI(req_wr),
        .ReqBEn_SI(req_ben), .ReqAddr_DI(req_addr), .ReqWrData_DI(req_wdata),
        .RspValid_SO(rsp_valid), .RspReady_SI(rsp_ready), .RspData_DO(rsp_data),
        .RamCSel_SO(ram_csel), .RamWrEn_SO(ram_wr), .RamBEn_SO(ram_ben),
        .RamAddr_DO(ram_addr), .RamWrData_DO(ram_wdata), .RamRdData_DI(ram_rdata)
    );

    spram_req_ctrl #(.ADDR_WIDTH(8), .OUT_REGS(1), .RSP_DEPTH(4)) dut1 (
        .Clk_CI(clk), .Rst_RBI(rst_n),
        .ReqValid_SI(req_valid1), .ReqReady_SO(req_ready1), .ReqWrEn_SI(req_wr1),
        .ReqBEn_SI(req_ben1), .ReqAddr_DI(req_addr1), .ReqWrData_DI(req_wdata1),
        .RspValid_SO(rsp_valid1), .RspReady_SI(rsp_ready1), .RspData_DO(rsp_data1),
        .RamCSel_SO(ram_csel1), .RamWrEn_SO(ram_wr1), .RamBEn_SO(ram_ben1),
        .RamAddr_DO(ram_addr1), .RamWrData_DO(ram_wdata1), .RamRdData_DI(ram_rdata1)
    );

    // Byte-enable RAM models: one read cycle, and one extra output register
    always @(posedge clk) begin
        if (ram_csel) begin
            if (ram_wr) begin
                for (int b = 0; b < 8; b++)
                    if (ram_ben[b]) ram0[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end else begin
                ram_rdata <= ram0[ram_addr];
            end
        end
    end

    always @(posedge clk) begin
        if (ram_csel1) begin
            if (ram_wr1) begin
                for (int b = 0; b < 8; b++)
                    if (ram_ben1[b]) ram1[ram_addr1][b*8 +: 8] <= ram_wdata1[b*8 +: 8];
            end else begin
                ram_rd1a <= ram1[ram_addr1];
            end
        end
        ram_rdata1 <= ram_rd1a;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle on the OUT_REGS=0 instance, checked against the scoreboard
    task automatic step(input logic v, input logic w, input logic [7:0] be,
                        input logic [7:0] a, input logic [63:0] d, input logic rr);
        logic exp_ready, exp_fire, exp_vld;
        rsp_t e;
        @(negedge clk);
        req_valid = v; req_wr = w; req_ben = be; req_addr = a; req_wdata = d; rsp_ready = rr;
        #1;
        obs_vld = rsp_valid; obs_data = rsp_data; obs_fire = ram_csel; obs_ready = req_ready;
        exp_ready = (q.size() < 4);
        exp_fire  = v & exp_ready;
        exp_vld   = (q.size() > 0) && (int'(q[0].due) <= cyc);
        check("req_ready", req_ready, exp_ready);
        check("ram_csel", ram_csel, exp_fire);
        check("ram_wren", ram_wr, exp_fire & w);
        check("ram_addr", ram_addr, a);
        check("rsp_valid", rsp_valid, exp_vld);
        if (exp_vld) check("rsp_data", rsp_data, q[0].data);
        if (exp_vld && rr) void'(q.pop_front());
        if (exp_fire && w) begin
            for (int b = 0; b < 8; b++)
                if (be[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
        end else if (exp_fire) begin
            e.data = shadow[a];
            e.due  = 32'(cyc + 2);
            q.push_back(e);
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 0; rsp_ready = 0; req_valid1 = 0; rsp_ready1 = 0;
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_ready1", req_ready1, 0);
        check("rst_rsp_valid1", rsp_valid1, 0);
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int acc;
        for (int i = 0; i < 256; i++) begin
            ram0[i] = '0; ram1[i] = '0; shadow[i] = '0;
        end
        req_valid = 0; req_wr = 0; req_ben = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
        req_valid1 = 0; req_wr1 = 0; req_ben1 = 0; req_addr1 = 0; req_wdata1 = 0; rsp_ready1 = 0;
        ram_rdata = '0; ram_rd1a = '0; ram_rdata1 = '0;
        do_reset();

        // OUT_REGS=1: write then read, response valid three cycles after the read fire
        @(negedge clk);
        req_valid1 = 1; req_wr1 = 1; req_ben1 = 8'hFF; req_addr1 = 8'h03;
        req_wdata1 = 64'hCAFE_F00D_1234_5678;
        #1 check("or1_ready_wr", req_ready1, 1);
        @(negedge clk);
        req_wr1 = 0;
        #1 check("or1_ready_rd", req_ready1, 1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            req_valid1 = 0;
            #1 check("or1_rsp_valid", rsp_valid1, (i >= 3) ? 1 : 0);
            if (i >= 3) check("or1_rsp_data", rsp_data1, 64'hCAFE_F00D_1234_5678);
        end
        @(negedge clk);
        rsp_ready1 = 1;
        @(negedge clk);
        rsp_ready1 = 0;
        #1 check("or1_popped", rsp_valid1, 0);

        // Partial write then read-back with two-cycle latency
        step(1, 1, 8'h0F, 8'h05, 64'h1122334455667788, 1);
        step(1, 0, 8'h00, 8'h05, 64'h0, 1);
        step(0, 0, 8'h00, 8'h00, 64'h0, 1);
        check("wr_rd_lat1", obs_vld, 0);
        step(0, 0, 8'h00, 8'h00, 64'h0, 1);
        check("wr_rd_vld", obs_vld, 1);
        check("wr_rd_data", obs_data, 64'h0000000055667788);

        // Back-to-back reads with the consumer always ready
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 8'h00, 8'(i), 64'h0, 1);
            check("b2b_ready", obs_ready, 1);
        end
        repeat (3) step(0, 0, 8'h00, 8'h00, 64'h0, 1);

        // Stalled consumer: exactly four reads accepted, then drain
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 8'h00, 8'(8 + i), 64'h0, 0);
            acc += int'(obs_fire);
        end
        check("stall_accepted", 64'(acc), 64'd4);
        check("stall_ready", obs_ready, 0);
        step(0, 0, 8'h00, 8'h00, 64'h0, 1);
        step(0, 0, 8'h00, 8'h00, 64'h0, 1);
        check("ready_after_pop", obs_ready, 1);
        repeat (4) step(0, 0, 8'h00, 8'h00, 64'h0, 1);

        // Reset with two reads in flight: nothing comes out afterwards
        step(1, 0, 8'h00, 8'h01, 64'h0, 0);
        step(1, 0, 8'h00, 8'h02, 64'h0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 8'h00, 8'h00, 64'h0, 1);
            check("post_rst_no_rsp", obs_vld, 0);
        end
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 8'h00, 8'(i), 64'h0, 0);
            acc += int'(obs_fire);
        end
        check("post_rst_credit", 64'(acc), 64'd4);
        repeat (6) step(0, 0, 8'h00, 8'h00, 64'h0, 1);

        // Random traffic, including simultaneous pop and read fire
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 10) < 7, ($urandom % 10) < 3, 8'($urandom),
                 8'($urandom % 16), {$urandom, $urandom},
                 (i % 200 < 100) ? 1'b1 : (($urandom % 10) < 5));
        end
        repeat (8) step(0, 0, 8'h00, 8'h00, 64'h0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
